// File: rtl/hazard_forward_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit_pkg: LC-3b forwarding/hazard types.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_forward_unit_pkg;

  localparam int LC3B_REG_W = 3;

  typedef logic [LC3B_REG_W-1:0] lc3b_reg;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_MEM     = 2'd1,
    FWD_WB      = 2'd2
  } lc3b_forward_EX_mux_sel;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MEM_WAIT = 2'd2
  } lc3b_hazard_state;

endpackage

`default_nettype wire

// File: rtl/hazard_forward_unit_fwd_sel_compute.sv
// ---------------------------------------------------------------------------
// fwd_sel_compute: one source operand vs EX/MEM producers -> forward select.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fwd_sel_compute
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_W = 3
) (
  input  logic [REG_W-1:0]      i_src,
  input  logic                  i_uses,
  input  logic                  i_ex_valid,
  input  logic [REG_W-1:0]      i_ex_dest,
  input  logic                  i_mem_valid,
  input  logic [REG_W-1:0]      i_mem_dest,
  output lc3b_forward_EX_mux_sel o_sel,
  output logic                  o_ex_hit
);

  logic w_mem_hit;

  assign o_ex_hit  = i_uses & i_ex_valid  & (i_ex_dest  == i_src);
  assign w_mem_hit = i_uses & i_mem_valid & (i_mem_dest == i_src);

  // Producer now in EX will sit in MEM when this operand reaches EX, hence FWD_MEM.
  always_comb begin
    o_sel = FWD_REGFILE;
    if (o_ex_hit) begin
      o_sel = FWD_MEM;
    end else if (w_mem_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit: EX forward selects, load-use bubble and stall control.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_W  = 3,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_sr1,
  input  logic [REG_W-1:0]  id_sr2,
  input  logic              id_uses_sr1,
  input  logic              id_uses_sr2,
  input  logic [REG_W-1:0]  id_dest,
  input  logic              id_load_regfile,
  input  logic              id_is_load,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              stall_fetch,
  output logic              bubble_ex,
  output logic              stall_pipe,
  output logic [1:0]        forward_EX_A_mux_sel,
  output logic [1:0]        forward_EX_B_mux_sel,
  output logic [PERF_W-1:0] perf_lu_stalls,
  output logic [PERF_W-1:0] perf_mem_stalls
);

  lc3b_hazard_state       r_state;
  lc3b_hazard_state       w_state_nxt;
  logic                   r_ex_valid;
  logic [REG_W-1:0]       r_ex_dest;
  logic                   r_ex_is_load;
  logic                   r_mem_valid;
  logic [REG_W-1:0]       r_mem_dest;
  logic [1:0]             r_sel_a;
  logic [1:0]             r_sel_b;
  logic [PERF_W-1:0]      r_lu_cnt;
  logic [PERF_W-1:0]      r_mem_cnt;
  lc3b_forward_EX_mux_sel w_sel_a;
  lc3b_forward_EX_mux_sel w_sel_b;
  logic                   w_hit_a;
  logic                   w_hit_b;
  logic                   w_hazard;
  logic                   w_bubble;
  logic                   w_stall_fetch;
  logic                   w_squash;

  fwd_sel_compute #(.REG_W(REG_W)) u_sel_a (
    .i_src       (id_sr1),
    .i_uses      (id_uses_sr1),
    .i_ex_valid  (r_ex_valid),
    .i_ex_dest   (r_ex_dest),
    .i_mem_valid (r_mem_valid),
    .i_mem_dest  (r_mem_dest),
    .o_sel       (w_sel_a),
    .o_ex_hit    (w_hit_a)
  );

  fwd_sel_compute #(.REG_W(REG_W)) u_sel_b (
    .i_src       (id_sr2),
    .i_uses      (id_uses_sr2),
    .i_ex_valid  (r_ex_valid),
    .i_ex_dest   (r_ex_dest),
    .i_mem_valid (r_mem_valid),
    .i_mem_dest  (r_mem_dest),
    .o_sel       (w_sel_b),
    .o_ex_hit    (w_hit_b)
  );

  assign w_hazard = id_valid & ~flush & r_ex_is_load & (w_hit_a | w_hit_b);

  always_comb begin
    w_state_nxt   = r_state;
    w_bubble      = 1'b0;
    w_stall_fetch = mem_stall;
    case (r_state)
      HZ_RUN: begin
        if (mem_stall) begin
          w_state_nxt = HZ_MEM_WAIT;
        end else if (w_hazard) begin
          w_state_nxt   = HZ_LU_STALL;
          w_bubble      = 1'b1;
          w_stall_fetch = 1'b1;
        end
      end
      HZ_LU_STALL: begin
        w_state_nxt = mem_stall ? HZ_MEM_WAIT : HZ_RUN;
      end
      HZ_MEM_WAIT: begin
        // The pipe advances on the release cycle, so a pending load-use must still bubble.
        if (!mem_stall) begin
          if (w_hazard) begin
            w_state_nxt   = HZ_LU_STALL;
            w_bubble      = 1'b1;
            w_stall_fetch = 1'b1;
          end else begin
            w_state_nxt = HZ_RUN;
          end
        end
      end
      default: w_state_nxt = HZ_RUN;
    endcase
  end

  assign w_squash = w_bubble | flush | ~id_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= HZ_RUN;
      r_ex_valid   <= 1'b0;
      r_ex_dest    <= '0;
      r_ex_is_load <= 1'b0;
      r_mem_valid  <= 1'b0;
      r_mem_dest   <= '0;
      r_sel_a      <= FWD_REGFILE;
      r_sel_b      <= FWD_REGFILE;
    end else begin
      r_state <= w_state_nxt;
      if (!mem_stall) begin
        // A taken branch squashes the instruction leaving EX as well as the one leaving ID.
        r_mem_valid  <= r_ex_valid & ~flush;
        r_mem_dest   <= r_ex_dest;
        r_ex_valid   <= ~w_squash & id_load_regfile;
        r_ex_dest    <= id_dest;
        r_ex_is_load <= ~w_squash & id_load_regfile & id_is_load;
        r_sel_a      <= w_squash ? FWD_REGFILE : w_sel_a;
        r_sel_b      <= w_squash ? FWD_REGFILE : w_sel_b;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lu_cnt  <= '0;
      r_mem_cnt <= '0;
    end else begin
      if (w_bubble && (r_lu_cnt != {PERF_W{1'b1}})) begin
        r_lu_cnt <= r_lu_cnt + PERF_W'(1);
      end
      if (mem_stall && (r_mem_cnt != {PERF_W{1'b1}})) begin
        r_mem_cnt <= r_mem_cnt + PERF_W'(1);
      end
    end
  end

  assign stall_fetch          = w_stall_fetch;
  assign bubble_ex            = w_bubble;
  assign stall_pipe           = mem_stall;
  assign forward_EX_A_mux_sel = r_sel_a;
  assign forward_EX_B_mux_sel = r_sel_b;
  assign perf_lu_stalls       = r_lu_cnt;
  assign perf_mem_stalls      = r_mem_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_unit: scoreboard bench for hazard_forward_unit.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_forward_unit;

  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [2:0]  id_sr1;
  logic [2:0]  id_sr2;
  logic        id_uses_sr1;
  logic        id_uses_sr2;
  logic [2:0]  id_dest;
  logic        id_load_regfile;
  logic        id_is_load;
  logic        mem_stall;
  logic        flush;
  logic        stall_fetch;
  logic        bubble_ex;
  logic        stall_pipe;
  logic [1:0]  sel_a;
  logic [1:0]  sel_b;
  logic [15:0] perf_lu;
  logic [15:0] perf_mem;

  logic        sat_ms;
  logic        sat_sf;
  logic        sat_bub;
  logic        sat_sp;
  logic [1:0]  sat_a;
  logic [1:0]  sat_b;
  logic [2:0]  sat_lu;
  logic [2:0]  sat_mem;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    string      tag;
  } exp_t;

  exp_t sb_q[$];

  hazard_forward_unit u_dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .id_valid             (id_valid),
    .id_sr1               (id_sr1),
    .id_sr2               (id_sr2),
    .id_uses_sr1          (id_uses_sr1),
    .id_uses_sr2          (id_uses_sr2),
    .id_dest              (id_dest),
    .id_load_regfile      (id_load_regfile),
    .id_is_load           (id_is_load),
    .mem_stall            (mem_stall),
    .flush                (flush),
    .stall_fetch          (stall_fetch),
    .bubble_ex            (bubble_ex),
    .stall_pipe           (stall_pipe),
    .forward_EX_A_mux_sel (sel_a),
    .forward_EX_B_mux_sel (sel_b),
    .perf_lu_stalls       (perf_lu),
    .perf_mem_stalls      (perf_mem)
  );

  // Narrow counters make saturation reachable in a few cycles.
  hazard_forward_unit #(.REG_W(3), .PERF_W(3)) u_sat (
    .clk                  (clk),
    .reset_n              (reset_n),
    .id_valid             (1'b0),
    .id_sr1               (3'd0),
    .id_sr2               (3'd0),
    .id_uses_sr1          (1'b0),
    .id_uses_sr2          (1'b0),
    .id_dest              (3'd0),
    .id_load_regfile      (1'b0),
    .id_is_load           (1'b0),
    .mem_stall            (sat_ms),
    .flush                (1'b0),
    .stall_fetch          (sat_sf),
    .bubble_ex            (sat_bub),
    .stall_pipe           (sat_sp),
    .forward_EX_A_mux_sel (sat_a),
    .forward_EX_B_mux_sel (sat_b),
    .perf_lu_stalls       (sat_lu),
    .perf_mem_stalls      (sat_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic v, input logic [2:0] s1, input logic u1,
                      input logic [2:0] s2, input logic u2, input logic [2:0] d,
                      input logic ld, input logic isld, input logic ms, input logic fl,
                      input logic e_sf, input logic e_bub,
                      input logic [1:0] e_a, input logic [1:0] e_b);
    exp_t e;
    exp_t got;
    @(negedge clk);
    id_valid        = v;
    id_sr1          = s1;
    id_uses_sr1     = u1;
    id_sr2          = s2;
    id_uses_sr2     = u2;
    id_dest         = d;
    id_load_regfile = ld;
    id_is_load      = isld;
    mem_stall       = ms;
    flush           = fl;
    #1;
    chk({tag, "_stall_fetch"}, 32'(stall_fetch), 32'(e_sf));
    chk({tag, "_bubble_ex"},   32'(bubble_ex),   32'(e_bub));
    chk({tag, "_stall_pipe"},  32'(stall_pipe),  32'(ms));
    e.a = e_a;
    e.b = e_b;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      chk({got.tag, "_sel_a"}, 32'(sel_a), 32'(got.a));
      chk({got.tag, "_sel_b"}, 32'(sel_b), 32'(got.b));
    end
  endtask

  task automatic alu(input string tag, input logic [2:0] d, input logic [2:0] s1,
                     input logic [2:0] s2, input logic [1:0] e_a, input logic [1:0] e_b);
    step(tag, 1'b1, s1, 1'b1, s2, 1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, e_a, e_b);
  endtask

  task automatic ldr(input string tag, input logic [2:0] d, input logic [2:0] base);
    step(tag, 1'b1, base, 1'b1, 3'd0, 1'b0, d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic nop2(input string tag);
    step({tag, "_nop0"}, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    step({tag, "_nop1"}, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    id_valid = 1'b0; id_sr1 = '0; id_sr2 = '0; id_uses_sr1 = 1'b0; id_uses_sr2 = 1'b0;
    id_dest = '0; id_load_regfile = 1'b0; id_is_load = 1'b0;
    mem_stall = 1'b0; flush = 1'b0; sat_ms = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_sel_a", 32'(sel_a), 32'd0);
    chk("rst_sel_b", 32'(sel_b), 32'd0);
    chk("rst_sf", 32'(stall_fetch), 32'd0);
    chk("rst_bub", 32'(bubble_ex), 32'd0);
    chk("rst_lu", 32'(perf_lu), 32'd0);
    chk("rst_mem", 32'(perf_mem), 32'd0);

    // Back-to-back dependency, then unused sr2 that would otherwise match.
    alu("t1_add_r1", 3'd1, 3'd2, 3'd3, 2'd0, 2'd0);
    alu("t1_add_r2", 3'd2, 3'd1, 3'd3, 2'd1, 2'd0);
    step("t1_imm", 1'b1, 3'd1, 1'b1, 3'd1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0);
    nop2("t1");

    alu("t2_add_r1", 3'd1, 3'd2, 3'd3, 2'd0, 2'd0);
    step("t2_nop", 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    alu("t2_add_r4", 3'd4, 3'd1, 3'd1, 2'd2, 2'd2);
    nop2("t2");

    ldr("t3_ldr", 3'd1, 3'd6);
    step("t3_bub", 1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
    alu("t3_use", 3'd2, 3'd1, 3'd1, 2'd2, 2'd2);
    chk("t3_perf_lu", 32'(perf_lu), 32'd1);
    nop2("t3");

    alu("t4_add_a", 3'd1, 3'd2, 3'd3, 2'd0, 2'd0);
    alu("t4_add_b", 3'd1, 3'd2, 3'd3, 2'd0, 2'd0);
    alu("t4_newest", 3'd5, 3'd1, 3'd3, 2'd1, 2'd0);
    nop2("t4");

    alu("t5_add_r1", 3'd1, 3'd2, 3'd3, 2'd0, 2'd0);
    alu("t5_add_r2", 3'd2, 3'd1, 3'd3, 2'd1, 2'd0);
    for (int i = 0; i < 4; i++) begin
      step("t5_stall", 1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0);
    end
    alu("t5_release", 3'd3, 3'd2, 3'd2, 2'd1, 2'd1);
    chk("t5_perf_mem", 32'(perf_mem), 32'd4);
    nop2("t5");

    ldr("t6_ldr", 3'd1, 3'd6);
    step("t6_flush", 1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
    alu("t6_after", 3'd3, 3'd1, 3'd1, 2'd0, 2'd0);
    chk("t6_perf_lu", 32'(perf_lu), 32'd1);
    nop2("t6");

    // R0 forwards like any register; a store (no regfile write) and an invalid slot never do.
    alu("t8_r0", 3'd0, 3'd2, 3'd3, 2'd0, 2'd0);
    alu("t8_r0_use", 3'd1, 3'd0, 3'd0, 2'd1, 2'd1);
    step("t8_store", 1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    alu("t8_st_use", 3'd4, 3'd6, 3'd1, 2'd0, 2'd2);
    step("t8_inval", 1'b0, 3'd4, 1'b1, 3'd4, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    alu("t8_inv_use", 3'd7, 3'd5, 3'd5, 2'd0, 2'd0);
    nop2("t8");

    ldr("t7_ldr", 3'd1, 3'd6);
    step("t7_bub", 1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0);
    chk("t7_perf_lu_pre", 32'(perf_lu), 32'd2);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t7_async_lu", 32'(perf_lu), 32'd0);
    chk("t7_async_mem", 32'(perf_mem), 32'd0);
    chk("t7_async_sf", 32'(stall_fetch), 32'd0);
    chk("t7_async_bub", 32'(bubble_ex), 32'd0);
    chk("t7_async_a", 32'(sel_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    alu("t7_post", 3'd2, 3'd1, 3'd1, 2'd0, 2'd0);

    @(negedge clk);
    sat_ms = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("sat_reach", 32'(sat_mem), 32'd7);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_hold", 32'(sat_mem), 32'd7);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
